ram_fill_engine: RTL

Parametrised memory-fill engine on the CPU clock domain. It clears or patterns a RAM region, typically the video framebuffer and palette areas, without the CPU looping over individual word writes. The CPU programs it through a register slave port sharing the SoC `sel/wren/address/wdata/rdata` convention. It drives a word-write master port towards `ram_memory`. Supported fill modes are constant fill and incrementing pattern, with abort and optional completion interrupt.

---
 rtl/ram_fill_engine_if.sv | 53 +++++
 rtl/ram_fill_engine.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram_fill_engine_if.sv
// Bus bundles for ram_fill_engine: CPU register port and RAM write port.
// ram_fill_engine_if: sel/wren/address/wdata/rdata; ram_fill_ram_if: word-write master.

interface ram_fill_engine_if;
    logic        sel;
    logic [3:0]  wren;
    logic [4:0]  address;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (
        output sel,
        output wren,
        output address,
        output wdata,
        input  rdata
    );

    modport slave (
        input  sel,
        input  wren,
        input  address,
        input  wdata,
        output rdata
    );
endinterface

interface ram_fill_ram_if #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 32
);
    logic                ram_valid;
    logic [DATA_W/8-1:0] ram_wstrb;
    logic [ADDR_W-1:0]   ram_addr;
    logic [DATA_W-1:0]   ram_wdata;
    logic                ram_ready;

    modport master (
        output ram_valid,
        output ram_wstrb,
        output ram_addr,
        output ram_wdata,
        input  ram_ready
    );

    modport slave (
        input  ram_valid,
        input  ram_wstrb,
        input  ram_addr,
        input  ram_wdata,
        output ram_ready
    );
endinterface

// File: rtl/ram_fill_engine.sv
// Memory-fill engine: constant or incrementing-pattern fill of a RAM region.
// Ports: clk_cpu, n_reset (async, active low), regs (register slave port),
// ram (word-write master), irq (only when RAM_FILL_IRQ_EN is defined; = DONE).
// Registers: 0x00 CTRL, 0x04 BASE, 0x08 COUNT, 0x0C PATTERN, 0x10 INCR,
// 0x14 REMAIN (read-only).

module ram_fill_engine #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk_cpu,
    input  logic              n_reset,
    ram_fill_engine_if.slave  regs,
    ram_fill_ram_if.master    ram
`ifdef RAM_FILL_IRQ_EN
    ,
    output logic              irq
`endif
);

    localparam int BYTES = DATA_W / 8;
    localparam int LANES = DATA_W / 32;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_e;

    // Byte-strobe merge of a register write.
    function automatic logic [31:0] merge(
        input logic [31:0] old_v,
        input logic [31:0] new_v,
        input logic [3:0]  be
    );
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
        end
        return r;
    endfunction

    // Low address bits below the beat size are forced to zero.
    localparam logic [ADDR_W-1:0] BASE_MASK = ~ADDR_W'(BYTES - 1);

    state_e            state_q, state_d;

    logic [ADDR_W-1:0] base_q, base_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [31:0]       pat_q, pat_d;
    logic [31:0]       incr_q, incr_d;
    logic              mode_q, mode_d;

    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [CNT_W-1:0]  remain_q, remain_d;
    logic [31:0]       wpat_q, wpat_d;
    logic [31:0]       wincr_q, wincr_d;

    logic              done_q, done_d;
    logic              aborted_q, aborted_d;
    logic [31:0]       rdata_q, rdata_d;

    logic              wr;
    logic              rd;
    logic              ctrl_b0;
    logic              start;
    logic              abort;
    logic              dclr;
    logic              busy;
    logic [31:0]       step;
    logic [DATA_W-1:0] beat;

    assign wr      = regs.sel && (regs.wren != 4'b0000);
    assign rd      = regs.sel && (regs.wren == 4'b0000);
    assign ctrl_b0 = wr && (regs.address == 5'h00) && regs.wren[0];
    assign start   = ctrl_b0 && regs.wdata[0];
    assign abort   = ctrl_b0 && regs.wdata[3];
    assign dclr    = ctrl_b0 && regs.wdata[4];
    assign busy    = (state_q == S_RUN);

    // Pattern advance per beat covers every 32-bit lane of the beat.
    assign step = 32'(LANES) * wincr_q;

    always_comb begin
        beat = '0;
        for (int i = 0; i < LANES; i++) begin
            beat[i*32 +: 32] = wpat_q + 32'(i) * wincr_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        count_d   = count_q;
        pat_d     = pat_q;
        incr_d    = incr_q;
        mode_d    = mode_q;
        waddr_d   = waddr_q;
        remain_d  = remain_q;
        wpat_d    = wpat_q;
        wincr_d   = wincr_q;
        done_d    = done_q;
        aborted_d = aborted_q;

        if (wr) begin
            case (regs.address)
                5'h04: base_d = ADDR_W'(merge(32'(base_q), regs.wdata,
                                              regs.wren)) & BASE_MASK;
                5'h08: count_d = CNT_W'(merge(32'(count_q), regs.wdata,
                                              regs.wren));
                5'h0C: pat_d = merge(pat_q, regs.wdata, regs.wren);
                5'h10: incr_d = merge(incr_q, regs.wdata, regs.wren);
                default: ;
            endcase
        end

        if (ctrl_b0) mode_d = regs.wdata[1];

        // Clear first so a start or completion in the same cycle wins.
        if (dclr) begin
            done_d    = 1'b0;
            aborted_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (count_q != '0) begin
                        state_d  = S_RUN;
                        waddr_d  = base_q;
                        remain_d = count_q;
                        wpat_d   = pat_q;
                        // Constant mode is an increment of zero.
                        wincr_d  = mode_d ? incr_q : 32'h0;
                    end else begin
                        done_d   = 1'b1;
                        remain_d = '0;
                    end
                end
            end
            S_RUN: begin
                if (ram.ram_ready) begin
                    waddr_d  = waddr_q + ADDR_W'(BYTES);
                    remain_d = remain_q - CNT_W'(1);
                    wpat_d   = wpat_q + step;
                    if (remain_q == CNT_W'(1)) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
                if (abort) begin
                    state_d   = S_IDLE;
                    done_d    = 1'b1;
                    aborted_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rdata_d = rdata_q;
        if (rd) begin
            case (regs.address)
                5'h00: rdata_d = {26'b0, aborted_q, 2'b00,
                                  done_q, mode_q, busy};
                5'h04: rdata_d = 32'(base_q);
                5'h08: rdata_d = 32'(count_q);
                5'h0C: rdata_d = pat_q;
                5'h10: rdata_d = incr_q;
                5'h14: rdata_d = 32'(remain_q);
                default: rdata_d = 32'h0;
            endcase
        end
    end

    always_ff @(posedge clk_cpu or negedge n_reset) begin
        if (!n_reset) begin
            state_q   <= S_IDLE;
            base_q    <= '0;
            count_q   <= '0;
            pat_q     <= '0;
            incr_q    <= '0;
            mode_q    <= 1'b0;
            waddr_q   <= '0;
            remain_q  <= '0;
            wpat_q    <= '0;
            wincr_q   <= '0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            count_q   <= count_d;
            pat_q     <= pat_d;
            incr_q    <= incr_d;
            mode_q    <= mode_d;
            waddr_q   <= waddr_d;
            remain_q  <= remain_d;
            wpat_q    <= wpat_d;
            wincr_q   <= wincr_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
            rdata_q   <= rdata_d;
        end
    end

    assign regs.rdata    = rdata_q;
    assign ram.ram_valid = busy;
    assign ram.ram_wstrb = busy ? '1 : '0;
    assign ram.ram_addr  = waddr_q;
    assign ram.ram_wdata = beat;

`ifdef RAM_FILL_IRQ_EN
    assign irq = done_q;
`endif

endmodule
